// File: rtl/md_pkg.sv
// md_pkg: op encodings, issue-class macro and shared types for the multiply/divide unit.
// Build option MD_MADD_EN adds the MADD/MSUB accumulate family to the multi-cycle op set.
`ifndef MD_PKG_SV
`define MD_PKG_SV

`define MD_NONE   4'd0
`define MD_MULT   4'd1
`define MD_MULTU  4'd2
`define MD_DIV    4'd3
`define MD_DIVU   4'd4
`define MD_MTHI   4'd5
`define MD_MTLO   4'd6
`define MD_MADD   4'd7
`define MD_MADDU  4'd8
`define MD_MSUB   4'd9
`define MD_MSUBU  4'd10

// Also used by the D-stage stall controller, which stalls on start|busy.
`ifdef MD_MADD_EN
`define MD_IS_MULTICYCLE(op) ((((op) >= `MD_MULT) && ((op) <= `MD_DIVU)) || (((op) >= `MD_MADD) && ((op) <= `MD_MSUBU)))
`else
`define MD_IS_MULTICYCLE(op) (((op) >= `MD_MULT) && ((op) <= `MD_DIVU))
`endif

package md_pkg;

   localparam int CNT_W = 6;

   typedef enum logic {ST_IDLE, ST_RUN} md_state_t;

   typedef enum logic {LAT_MULT, LAT_DIV} md_lat_t;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == `MD_DIV) || (op == `MD_DIVU);
   endfunction

endpackage

`endif

// File: rtl/md_if.sv
// md_if: issue/result bundle between the E stage and the multiply/divide unit.
// master = E-stage issue side, slave = md_unit.
interface md_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, hi, lo);
   modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_core.sv
// md_core: combinational datapath producing the pending HI/LO for an issued op.
// Accumulate path exists only when MD_MADD_EN is defined.
module md_core
   import md_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] pending_hi,
   output logic [WIDTH-1:0] pending_lo,
   output logic             div_by_zero,
   output md_lat_t          latency_sel
);
   localparam int W2 = 2 * WIDTH;

   logic             signed_op;
   logic [W2-1:0]    a_ext;
   logic [W2-1:0]    b_ext;
   logic [W2-1:0]    prod;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] quo_mag;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [W2-1:0]    result;

   assign signed_op = (op == `MD_MULT) || (op == `MD_DIV) ||
                      (op == `MD_MADD) || (op == `MD_MSUB);

   // The low 2*WIDTH bits of an extended product are exact for both signednesses.
   assign a_ext = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod  = a_ext * b_ext;

   // Divide on magnitudes so most-negative / -1 wraps back to most-negative.
   assign a_neg       = signed_op & a[WIDTH-1];
   assign b_neg       = signed_op & b[WIDTH-1];
   assign a_mag       = a_neg ? -a : a;
   assign b_mag       = b_neg ? -b : b;
   assign div_by_zero = (b == '0);
   assign quo_mag     = div_by_zero ? '0 : a_mag / b_mag;
   assign rem_mag     = div_by_zero ? '0 : a_mag % b_mag;
   assign quo         = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
   assign rem         = a_neg ? -rem_mag : rem_mag;

   always_comb begin
      result      = prod;
      latency_sel = LAT_MULT;
      if (is_div_op(op)) begin
         result      = {rem, quo};
         latency_sel = LAT_DIV;
      end
`ifdef MD_MADD_EN
      else if ((op == `MD_MADD) || (op == `MD_MADDU)) begin
         result = {hi, lo} + prod;
      end
      else if ((op == `MD_MSUB) || (op == `MD_MSUBU)) begin
         result = {hi, lo} - prod;
      end
`endif
   end

`ifndef MD_MADD_EN
   logic unused_acc;
   assign unused_acc = ^{hi, lo};
`endif

   assign pending_hi = result[W2-1:WIDTH];
   assign pending_lo = result[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide with architectural HI/LO, busy for a fixed latency.
// Build option MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (see md_pkg / md_core).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accepting start; MTHI/MTLO write directly, mult/div issue
//   ST_RUN  | counting down; pending HI/LO commit when counter hits 0
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input logic clk,
   input logic reset_n,
   md_if.slave bus
);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_t        state;
   md_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic             pend_dbz;
   logic             issue;
   logic             commit;
   logic             mt_hi;
   logic             mt_lo;

   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo;
   logic             core_dbz;
   md_lat_t          core_lat;

   md_core #(.WIDTH(WIDTH)) u_core (
      .op          (bus.op),
      .a           (bus.a),
      .b           (bus.b),
      .hi          (hi_q),
      .lo          (lo_q),
      .pending_hi  (core_hi),
      .pending_lo  (core_lo),
      .div_by_zero (core_dbz),
      .latency_sel (core_lat)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      issue     = 1'b0;
      commit    = 1'b0;
      mt_hi     = 1'b0;
      mt_lo     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (`MD_IS_MULTICYCLE(bus.op)) begin
                  issue     = 1'b1;
                  state_nxt = ST_RUN;
                  cnt_nxt   = (core_lat == LAT_DIV) ? DIV_LOAD : MULT_LOAD;
               end else if (bus.op == `MD_MTHI) begin
                  mt_hi = 1'b1;
               end else if (bus.op == `MD_MTLO) begin
                  mt_lo = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (cnt == '0) begin
               commit    = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         pend_hi  <= '0;
         pend_lo  <= '0;
         pend_dbz <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (issue) begin
            pend_hi  <= core_hi;
            pend_lo  <= core_lo;
            pend_dbz <= core_dbz & (core_lat == LAT_DIV);
         end
         // Divide by zero still spends the full latency but leaves HI/LO alone.
         if (commit && !pend_dbz) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
         end
         if (mt_hi) hi_q <= bus.a;
         if (mt_lo) lo_q <= bus.a;
      end
   end

   assign bus.busy = (state == ST_RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

`ifndef SYNTHESIS
   // The pipeline never issues into a busy unit; the RTL drops such a start.
   always @(posedge clk) begin
      if (reset_n) begin
         assert (!(bus.start && bus.busy))
            else $warning("md_unit: start while busy dropped");
      end
   end
`endif

endmodule
